vga_rx_monitor: RTL and testbench
=================================

VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, pixel periods per line.
REQ-002 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-003 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-004 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-005 SHALL have port Clk  input  1  system clock (MAX10_CLK1_50 domain); one clock only.
REQ-006 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port pix_en  input  1  pixel-period strobe, one Clk cycle wide; all video inputs are sampled only on pix_en cycles.
REQ-008 SHALL have port hs  input  1  horizontal sync, active-low.
REQ-009 SHALL have port vs  input  1  vertical sync, active-low.
REQ-010 SHALL have port blank  input  1  1 = active video, 0 = blanking.
REQ-011 SHALL have port R_in, G_in, B_in  input  4 each  pixel colour.
REQ-012 SHALL have port probe_x, probe_y  input  10 each  probe coordinate.
REQ-013 SHALL have port rx_x, rx_y  output  10 each  recovered active-pixel coordinate.
REQ-014 SHALL have port line_len  output  10  pixel periods in the last completed line.
REQ-015 SHALL have port frame_lines  output  10  lines in the last completed frame.
REQ-016 SHALL have port locked  output  1  the timing matches the parameters.
REQ-017 SHALL have port err_sticky  output  1  a timing error was seen since reset.
REQ-018 SHALL have port frame_cnt  output  8  count of frames completed while locked.
REQ-019 SHALL have port probe_rgb  output  12  colour captured at the probe, as {R,G,B}.
REQ-020 SHALL have port probe_valid  output  1  one-Clk pulse when probe_rgb updates.

Function
REQ-021 SHALL register hs/vs on pix_en cycles and detect falling edges (previous 1, current 0) on those samples only.
REQ-022 SHALL count pix_en ticks in hcnt: 0 on the hs falling-edge tick, +1 on every other tick, saturating at 1023; on that edge tick line_len <= hcnt_prev+1, saturating at 1023.
REQ-023 SHALL count hs falling edges in vcnt: 0 on the vs falling-edge tick, saturating at 1023; on that edge tick frame_lines <= vcnt_prev+1.
REQ-024 SHALL, on an hs edge and a vs edge in the same tick, apply the line update before the frame update, so the closing line is counted.
REQ-025 SHALL implement an FSM with states SEARCH, ALIGN and LOCKED; locked=1 only in LOCKED.
REQ-026 SHALL move from SEARCH to ALIGN on a vs falling edge.
REQ-027 SHALL, in ALIGN, on the next vs edge go to LOCKED if every line length was H_TOTAL and the frame had V_TOTAL lines; otherwise it SHALL go to SEARCH.
REQ-028 SHALL, in LOCKED, on any line_len != H_TOTAL (checked at hs edge) or frame_lines != V_TOTAL (checked at vs edge), set err_sticky and go to SEARCH in the next Clk.
REQ-029 SHALL treat hcnt saturation (no hs for 1024 ticks) as an error: set err_sticky when in LOCKED, and go to SEARCH from any state.
REQ-030 SHALL increment frame_cnt, wrapping 255->0, on each vs edge that keeps the FSM in LOCKED.
REQ-031 SHALL advance rx_x by 1 on each pix_en tick with blank=1, and clear rx_x on each hs falling edge.
REQ-032 SHALL advance rx_y by 1 on each hs edge that follows a line containing an active pixel, and clear rx_y on each vs edge; rx_x and rx_y saturate at 1023.
REQ-033 SHALL, in LOCKED, on a pix_en tick with blank=1, rx_x==probe_x and rx_y==probe_y, latch {R_in,G_in,B_in} into probe_rgb and assert probe_valid for exactly the next Clk cycle.
REQ-034 SHALL never update probe_rgb outside LOCKED.
REQ-035 SHALL never pulse probe_valid on a pixel that is not active, even when the coordinates match.
REQ-036 SHALL accept probe_x/probe_y changes at any time, taking effect on the next pix_en tick.
REQ-037 SHALL ignore hs, vs, blank and colour inputs on cycles with pix_en=0.

Reset
REQ-038 SHALL, while Reset_n=0, asynchronously force FSM=SEARCH and clear every counter, register and output (rx_x, rx_y, line_len, frame_lines, frame_cnt, probe_rgb all 0; locked, err_sticky, probe_valid all 0).
REQ-039 SHALL, on reset assertion mid-frame, apply REQ-038 immediately, and SHALL resume edge detection with a previous-sample value of 1 on hs/vs.
REQ-040 SHALL clear err_sticky only by reset.

Verification
REQ-041 SHALL pass: reset, then 3 nominal 800x525 frames (pix_en every 2nd Clk) -> locked=1 after the 2nd vs edge, frame_cnt=1 after the 3rd, line_len=800, frame_lines=525, err_sticky=0.
REQ-042 SHALL pass: locked, with one line of 799 periods -> err_sticky=1, locked=0 in the Clk after that hs edge; relock after 2 further good frames.
REQ-043 SHALL pass: probe (100,50) with pixel (100,50)=0xABC -> probe_rgb=0xABC, probe_valid one Clk high, once per frame.
REQ-044 SHALL pass: probe (700,10), outside the active area -> probe_valid never pulses.
REQ-045 SHALL pass: hs held high for 1100 ticks while locked -> err_sticky=1, state SEARCH.
REQ-046 SHALL pass: Reset_n pulsed low mid-frame -> all outputs 0 asynchronously, and locked again after 2 clean frames.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// Recovers VGA timing from hs/vs/blank, locks against the nominal raster and captures the colour at a probe pixel.
// Latency: all outputs are registered and update one Clk after the pix_en tick that caused them.
// Backpressure: none; inputs are sampled only on pix_en strobes and there is no flow control.
module vga_rx_monitor #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        pix_en,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank,
    input  logic [3:0]  R_in,
    input  logic [3:0]  G_in,
    input  logic [3:0]  B_in,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic        locked,
    output logic        err_sticky,
    output logic [7:0]  frame_cnt,
    output logic [11:0] probe_rgb,
    output logic        probe_valid
);

    typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_t;

    localparam logic [9:0] CNT_MAX    = 10'h3FF;
    localparam logic [9:0] H_TOTAL_W  = 10'(H_TOTAL);
    localparam logic [9:0] V_TOTAL_W  = 10'(V_TOTAL);
    localparam logic [9:0] H_ACTIVE_W = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACTIVE_W = 10'(V_ACTIVE);

    state_t     state;
    logic       hs_prev, vs_prev;
    logic       hs_fall, vs_fall, hsat, line_err, frame_err, probe_hit;
    logic       line_active, lines_ok;
    logic [9:0] hcnt, vcnt, hlen_new, flen_new;

    always_comb begin
        hs_fall   = pix_en && hs_prev && !hs;
        vs_fall   = pix_en && vs_prev && !vs;
        hlen_new  = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 10'd1;
        flen_new  = (vcnt == CNT_MAX) ? CNT_MAX : vcnt + 10'd1;
        hsat      = pix_en && !hs_fall && (hcnt == CNT_MAX);
        line_err  = hs_fall && (hlen_new != H_TOTAL_W);
        frame_err = vs_fall && (flen_new != V_TOTAL_W);
        probe_hit = pix_en && blank && (rx_x == probe_x) && (rx_y == probe_y)
                    && (probe_x < H_ACTIVE_W) && (probe_y < V_ACTIVE_W);
    end

    // Line/frame measurement; lines_ok covers every line closed since the last vs edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            hcnt        <= '0;
            vcnt        <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            lines_ok    <= 1'b0;
        end else if (pix_en) begin
            hs_prev <= hs;
            vs_prev <= vs;
            if (hs_fall) begin
                hcnt     <= '0;
                line_len <= hlen_new;
            end else if (hcnt != CNT_MAX) begin
                hcnt <= hcnt + 10'd1;
            end
            if (vs_fall) begin
                vcnt        <= '0;
                frame_lines <= flen_new;
            end else if (hs_fall && vcnt != CNT_MAX) begin
                vcnt <= vcnt + 10'd1;
            end
            if (vs_fall)
                lines_ok <= 1'b1;
            else if (line_err)
                lines_ok <= 1'b0;
        end
    end

    // The line closing on a vs edge is judged together with the frame it ends.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= SEARCH;
            locked     <= 1'b0;
            err_sticky <= 1'b0;
            frame_cnt  <= '0;
        end else if (hsat) begin
            if (state == LOCKED)
                err_sticky <= 1'b1;
            state  <= SEARCH;
            locked <= 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (vs_fall)
                        state <= ALIGN;
                end
                ALIGN: begin
                    if (vs_fall) begin
                        if (lines_ok && !line_err && !frame_err) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    if (line_err || frame_err) begin
                        err_sticky <= 1'b1;
                        state      <= SEARCH;
                        locked     <= 1'b0;
                    end else if (vs_fall) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_x        <= '0;
            rx_y        <= '0;
            line_active <= 1'b0;
            probe_rgb   <= '0;
            probe_valid <= 1'b0;
        end else begin
            probe_valid <= 1'b0;
            if (pix_en) begin
                if (hs_fall)
                    rx_x <= '0;
                else if (blank && rx_x != CNT_MAX)
                    rx_x <= rx_x + 10'd1;
                if (hs_fall)
                    line_active <= 1'b0;
                else if (blank)
                    line_active <= 1'b1;
                if (vs_fall)
                    rx_y <= '0;
                else if (hs_fall && line_active && rx_y != CNT_MAX)
                    rx_y <= rx_y + 10'd1;
                if (state == LOCKED && probe_hit) begin
                    probe_rgb   <= {R_in, G_in, B_in};
                    probe_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a scaled-down 24x14 raster (16x10 active), pix_en every second Clk.
module tb_vga_rx_monitor;

    localparam int HT = 24, VT = 14, HA = 16, VA = 10;
    localparam int HS_W = 3, H_ACT0 = 6, V_SYNC = 2, V_ACT0 = 2;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        hs = 1'b1, vs = 1'b1, blank = 1'b0;
    logic [3:0]  R_in = '0, G_in = '0, B_in = '0;
    logic [9:0]  probe_x = 10'd5, probe_y = 10'd3;
    logic [9:0]  rx_x, rx_y, line_len, frame_lines;
    logic        locked, err_sticky, probe_valid;
    logic [7:0]  frame_cnt;
    logic [11:0] probe_rgb;

    int checks = 0;
    int errors = 0;
    int pv_total = 0;

    vga_rx_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
        .Clk(clk), .Reset_n(Reset_n), .pix_en(pix_en), .hs(hs), .vs(vs), .blank(blank),
        .R_in(R_in), .G_in(G_in), .B_in(B_in), .probe_x(probe_x), .probe_y(probe_y),
        .rx_x(rx_x), .rx_y(rx_y), .line_len(line_len), .frame_lines(frame_lines),
        .locked(locked), .err_sticky(err_sticky), .frame_cnt(frame_cnt),
        .probe_rgb(probe_rgb), .probe_valid(probe_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (probe_valid === 1'b1) pv_total++;

    typedef struct {
        string       name;
        int          bad;
        logic [9:0]  px, py;
        logic        lk, er;
        logic [7:0]  fc;
        logic [9:0]  ll, fl;
        int          pv;
        logic [11:0] rgb;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] colour(input int x, input int y);
        logic [3:0] xi, yi;
        xi = x[3:0];
        yi = y[3:0];
        if (x == 5 && y == 3) return 12'hABC;
        return {xi, yi, 4'hF ^ xi};
    endfunction

    // One pixel period; the off cycle carries junk that must be ignored.
    task automatic pix(input logic h, input logic v, input logic b, input logic [11:0] rgb);
        @(negedge clk);
        pix_en = 1'b1;
        hs = h; vs = v; blank = b;
        {R_in, G_in, B_in} = rgb;
        @(negedge clk);
        pix_en = 1'b0;
        hs = ($urandom_range(0, 1) != 0);
        vs = ($urandom_range(0, 1) != 0);
        blank = ($urandom_range(0, 1) != 0);
        {R_in, G_in, B_in} = 12'($urandom);
    endtask

    task automatic do_line(input int y, input int len, input bit chk_bad);
        logic act;
        for (int t = 0; t < len; t++) begin
            act = (y >= V_ACT0) && (y < V_ACT0 + VA) && (t >= H_ACT0) && (t < H_ACT0 + HA);
            pix(t >= HS_W, y >= V_SYNC, act, act ? colour(t - H_ACT0, y - V_ACT0) : 12'h000);
            if (chk_bad && t == 0) begin
                check("badline_unlock", 64'(locked), 64'(0));
                check("badline_err", 64'(err_sticky), 64'(1));
                check("badline_len", 64'(line_len), 64'(HT - 1));
            end
        end
    endtask

    task automatic do_frame(input int bad, input int first, input int last);
        for (int y = first; y <= last; y++)
            do_line(y, (y == bad) ? HT - 1 : HT, (bad >= 0) && (y == bad + 1));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({rx_x, rx_y, line_len, frame_lines, frame_cnt, probe_rgb,
                    locked, err_sticky, probe_valid});
    endfunction

    initial begin
        int pv0;
        //           name       bad px      py     lk    er    fc    ll      fl      pv rgb
        tbl[0] = '{"align",    -1, 10'd5,  10'd3, 1'b0, 1'b0, 8'd0, 10'd24, 10'd1,  0, 12'h000};
        tbl[1] = '{"lock",     -1, 10'd5,  10'd3, 1'b1, 1'b0, 8'd0, 10'd24, 10'd14, 1, 12'hABC};
        tbl[2] = '{"count",    -1, 10'd5,  10'd3, 1'b1, 1'b0, 8'd1, 10'd24, 10'd14, 1, 12'hABC};
        tbl[3] = '{"badline",   7, 10'd5,  10'd3, 1'b0, 1'b1, 8'd2, 10'd24, 10'd14, 1, 12'hABC};
        tbl[4] = '{"realign",  -1, 10'd5,  10'd3, 1'b0, 1'b1, 8'd2, 10'd24, 10'd14, 0, 12'hABC};
        tbl[5] = '{"relock",   -1, 10'd5,  10'd3, 1'b1, 1'b1, 8'd2, 10'd24, 10'd14, 1, 12'hABC};
        tbl[6] = '{"outside",  -1, 10'd20, 10'd3, 1'b1, 1'b1, 8'd3, 10'd24, 10'd14, 0, 12'hABC};
        tbl[7] = '{"origin",   -1, 10'd0,  10'd3, 1'b1, 1'b1, 8'd4, 10'd24, 10'd14, 1, 12'h03F};

        #12;
        check("reset_outputs", all_outs(), 64'(0));
        @(negedge clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) pix(1'b1, 1'b1, 1'b0, 12'h000);

        for (int i = 0; i < 8; i++) begin
            probe_x = tbl[i].px;
            probe_y = tbl[i].py;
            pv0 = pv_total;
            do_frame(tbl[i].bad, 0, VT - 1);
            check($sformatf("%s.locked", tbl[i].name), 64'(locked), 64'(tbl[i].lk));
            check($sformatf("%s.err", tbl[i].name), 64'(err_sticky), 64'(tbl[i].er));
            check($sformatf("%s.frame_cnt", tbl[i].name), 64'(frame_cnt), 64'(tbl[i].fc));
            check($sformatf("%s.line_len", tbl[i].name), 64'(line_len), 64'(tbl[i].ll));
            check($sformatf("%s.frame_lines", tbl[i].name), 64'(frame_lines), 64'(tbl[i].fl));
            check($sformatf("%s.pv_pulses", tbl[i].name), 64'(pv_total - pv0), 64'(tbl[i].pv));
            check($sformatf("%s.probe_rgb", tbl[i].name), 64'(probe_rgb), 64'(tbl[i].rgb));
        end

        // Reset mid-frame: outputs clear without a clock edge, then relock on clean frames.
        do_frame(-1, 0, 5);
        check("pre_reset_locked", 64'(locked), 64'(1));
        check("pre_reset_fcnt", 64'(frame_cnt), 64'(5));
        @(negedge clk);
        #2 Reset_n = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 64'(0));
        @(negedge clk);
        check("held_reset_outputs", all_outs(), 64'(0));
        Reset_n = 1'b1;
        do_frame(-1, 6, VT - 1);
        pv0 = pv_total;
        do_frame(-1, 0, VT - 1);
        check("rst_align_locked", 64'(locked), 64'(0));
        check("rst_align_err", 64'(err_sticky), 64'(0));
        check("rst_align_lines", 64'(frame_lines), 64'(9));
        check("rst_align_pv", 64'(pv_total - pv0), 64'(0));
        pv0 = pv_total;
        do_frame(-1, 0, VT - 1);
        check("rst_relock_locked", 64'(locked), 64'(1));
        check("rst_relock_err", 64'(err_sticky), 64'(0));
        check("rst_relock_fcnt", 64'(frame_cnt), 64'(0));
        check("rst_relock_lines", 64'(frame_lines), 64'(14));
        check("rst_relock_pv", 64'(pv_total - pv0), 64'(1));
        check("rst_relock_rgb", 64'(probe_rgb), 64'(12'h03F));

        // hs stuck high while locked: hcnt saturation must drop lock and flag an error.
        for (int i = 0; i < 1100; i++) pix(1'b1, 1'b1, 1'b0, 12'h000);
        check("hs_stuck_err", 64'(err_sticky), 64'(1));
        check("hs_stuck_locked", 64'(locked), 64'(0));
        check("hs_stuck_line_len", 64'(line_len), 64'(24));
        check("hs_stuck_fcnt", 64'(frame_cnt), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
